lorenz_fx_stream: RTL and testbench

//  Parametrised fixed-point Lorenz chaotic-sequence generator; replaces the double-FPU iterator.

---
 rtl/lorenz_pkg.sv | 61 ++++++
 rtl/lorenz_fx_mul.sv | 34 +++
 rtl/lorenz_fx_stream.sv | 251 +++++++++++++++++++++++++
 tb/tb_lorenz_fx_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lorenz_pkg.sv
// lorenz_pkg
// Shared definitions for the fixed-point Lorenz generator:
//   - lz_state_e : sequencer states (IDLE, C1..C6, EMIT)
//   - to_q       : integer -> Q-format helper used for the coefficient defaults
//   - default SIGMA/RHO/BETA coefficients, given as integer or ratio terms
//   - lz_reduce  : narrows a wide signed value to w bits, either by wrapping
//                  (keep the low w bits) or by saturating, and reports a clip
package lorenz_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_C1   = 3'd1,
      ST_C2   = 3'd2,
      ST_C3   = 3'd3,
      ST_C4   = 3'd4,
      ST_C5   = 3'd5,
      ST_C6   = 3'd6,
      ST_EMIT = 3'd7
   } lz_state_e;

   // Default coefficients: sigma = 10, rho = 28, beta = 8/3 (truncated in Q).
   localparam int LZ_SIGMA_INT = 10;
   localparam int LZ_RHO_INT   = 28;
   localparam int LZ_BETA_NUM  = 8;
   localparam int LZ_BETA_DEN  = 3;

   typedef struct packed {
      logic              clip;
      logic signed [63:0] val;
   } lz_red_t;

   function automatic longint to_q(input int ival, input int frac);
      return longint'(ival) <<< frac;
   endfunction

   // Result is sign-extended into 64 bits; callers keep the low w bits.
   function automatic lz_red_t lz_reduce(input logic signed [127:0] v,
                                         input int                  w,
                                         input bit                  sat_en);
      logic signed [127:0] maxv;
      logic signed [127:0] minv;
      logic signed [127:0] wr;
      lz_red_t             r;
      maxv   = (128'sd1 <<< (w - 1)) - 128'sd1;
      minv   = -(128'sd1 <<< (w - 1));
      wr     = (v <<< (128 - w)) >>> (128 - w);
      r.clip = 1'b0;
      r.val  = wr[63:0];
      if (sat_en) begin
         if (v > maxv) begin
            r.val  = maxv[63:0];
            r.clip = 1'b1;
         end else if (v < minv) begin
            r.val  = minv[63:0];
            r.clip = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lorenz_fx_mul.sv
// lorenz_fx_mul
// Signed (W+1)x(W+1) multiplier with a registered product (1-cycle latency).
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears the product)
//   a_i, b_i   : signed W+1 bit operands
//   p_o        : signed 2W+2 bit product of the operands from the previous cycle
module lorenz_fx_mul #(
   parameter int W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [W:0]     a_i,
   input  logic signed [W:0]     b_i,
   output logic signed [2*W+1:0] p_o
);

   logic signed [2*W+1:0] p_q;
   logic signed [2*W+1:0] p_d;

   always_comb begin
      p_d = $signed({{(W+1){a_i[W]}}, a_i}) * $signed({{(W+1){b_i[W]}}, b_i});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/lorenz_fx_stream.sv
// lorenz_fx_stream
// Fixed-point Lorenz chaotic-sequence generator. Each step is a forward-Euler
// update of dx=S(y-x), dy=x(R-z)-y, dz=xy-Bz, computed over six cycles with a
// single registered multiplier; finished samples go out on a valid/ready stream.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start_i                : pulse; latches seeds and begins a run (only in IDLE)
//   seed_x/y/z_i           : initial state, sampled on an accepted start
//   out_valid_o            : sample available (held until accepted)
//   out_ready_i            : consumer accept
//   x/y/z_out_o            : current state; frozen while out_valid_o is high
//   busy_o                 : high from accepted start until the run ends
//   done_o                 : one-cycle pulse after the final sample is accepted
//   sat_flag_o             : sticky clip indicator
//
// Build option LORENZ_SAT_EN: when defined, every narrowing to W bits saturates
// and sat_flag_o records any clip (cleared by reset or an accepted start).
// When undefined, narrowing wraps and sat_flag_o is constant 0.
//
// state   | meaning
// IDLE    | waiting for start, outputs hold last sample
// C1      | mul S*(y-x)
// C2      | dx <= p>>>F ; mul x*(R-z)
// C3      | dy <= (p>>>F)-y ; mul x*y
// C4      | t <= p>>>F ; mul B*z
// C5      | dz <= t-(p>>>F)
// C6      | x/y/z += d>>>H_SHIFT ; warm-up left ? C1 : EMIT
// EMIT    | out_valid high, wait for accept
module lorenz_fx_stream
   import lorenz_pkg::*;
#(
   parameter int                 W       = 32,
   parameter int                 F       = 24,
   parameter int                 H_SHIFT = 8,
   parameter logic signed [W-1:0] SIGMA  = W'(to_q(LZ_SIGMA_INT, F)),
   parameter logic signed [W-1:0] RHO    = W'(to_q(LZ_RHO_INT, F)),
   parameter logic signed [W-1:0] BETA   = W'(to_q(LZ_BETA_NUM, F) / LZ_BETA_DEN),
   parameter int                 SKIP    = 0,
   parameter int                 NSAMP   = 65536
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic signed [W-1:0] seed_x_i,
   input  logic signed [W-1:0] seed_y_i,
   input  logic signed [W-1:0] seed_z_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic signed [W-1:0] x_out_o,
   output logic signed [W-1:0] y_out_o,
   output logic signed [W-1:0] z_out_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                sat_flag_o
);

   localparam int PW = 2 * W + 2;

   lz_state_e state_q, state_d;
   logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d, t_q, t_d;
   logic [15:0]         skip_q, skip_d;
   logic [16:0]         samp_q, samp_d;
   logic                done_q, done_d;
   logic                clip;
   logic                start_acc;

   logic signed [W:0]    mul_a, mul_b;
   logic signed [PW-1:0] p;
   logic signed [W:0]    y_m_x, rho_m_z;
   logic signed [127:0]  p_ext, p_sh;
   lz_red_t              red_ps, red_dy, red_dz, red_x, red_y, red_z;

   function automatic logic signed [127:0] sx(input logic signed [W-1:0] v);
      return {{(128 - W){v[W-1]}}, v};
   endfunction

`ifdef LORENZ_SAT_EN
   localparam bit SAT_EN = 1'b1;
   logic sat_q, sat_d;

   always_comb begin
      sat_d = sat_q | clip;
      if (start_acc) begin
         sat_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign sat_flag_o = sat_q;
`else
   localparam bit SAT_EN = 1'b0;
   assign sat_flag_o = 1'b0;
`endif

   lorenz_fx_mul #(.W(W)) u_mul (
      .clk   (clk),
      .reset (reset),
      .a_i   (mul_a),
      .b_i   (mul_b),
      .p_o   (p)
   );

   // Differences feed the multiplier at W+1 bits so they never overflow.
   assign y_m_x   = {y_q[W-1], y_q} - {x_q[W-1], x_q};
   assign rho_m_z = {RHO[W-1], RHO} - {z_q[W-1], z_q};
   assign p_ext   = {{(128 - PW){p[PW-1]}}, p};
   assign p_sh    = p_ext >>> F;

   always_comb begin
      red_ps = lz_reduce(p_sh, W, SAT_EN);
      red_dy = lz_reduce(p_sh - sx(y_q), W, SAT_EN);
      red_dz = lz_reduce(sx(t_q) - p_sh, W, SAT_EN);
      red_x  = lz_reduce(sx(x_q) + (sx(dx_q) >>> H_SHIFT), W, SAT_EN);
      red_y  = lz_reduce(sx(y_q) + (sx(dy_q) >>> H_SHIFT), W, SAT_EN);
      red_z  = lz_reduce(sx(z_q) + (sx(dz_q) >>> H_SHIFT), W, SAT_EN);
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      dz_d      = dz_q;
      t_d       = t_q;
      skip_d    = skip_q;
      samp_d    = samp_q;
      done_d    = 1'b0;
      clip      = 1'b0;
      start_acc = 1'b0;
      mul_a     = '0;
      mul_b     = '0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               x_d       = seed_x_i;
               y_d       = seed_y_i;
               z_d       = seed_z_i;
               skip_d    = 16'(SKIP);
               samp_d    = 17'(NSAMP);
               state_d   = ST_C1;
            end
         end
         ST_C1: begin
            mul_a   = {SIGMA[W-1], SIGMA};
            mul_b   = y_m_x;
            state_d = ST_C2;
         end
         ST_C2: begin
            dx_d    = red_ps.val[W-1:0];
            clip    = red_ps.clip;
            mul_a   = {x_q[W-1], x_q};
            mul_b   = rho_m_z;
            state_d = ST_C3;
         end
         ST_C3: begin
            dy_d    = red_dy.val[W-1:0];
            clip    = red_dy.clip;
            mul_a   = {x_q[W-1], x_q};
            mul_b   = {y_q[W-1], y_q};
            state_d = ST_C4;
         end
         ST_C4: begin
            t_d     = red_ps.val[W-1:0];
            clip    = red_ps.clip;
            mul_a   = {BETA[W-1], BETA};
            mul_b   = {z_q[W-1], z_q};
            state_d = ST_C5;
         end
         ST_C5: begin
            dz_d    = red_dz.val[W-1:0];
            clip    = red_dz.clip;
            state_d = ST_C6;
         end
         ST_C6: begin
            x_d  = red_x.val[W-1:0];
            y_d  = red_y.val[W-1:0];
            z_d  = red_z.val[W-1:0];
            clip = red_x.clip | red_y.clip | red_z.clip;
            // Warm-up steps are counted down only once, right after start.
            if (skip_q != 16'd0) begin
               skip_d  = skip_q - 16'd1;
               state_d = ST_C1;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready_i) begin
               state_d = ST_C1;
               if (NSAMP != 0) begin
                  samp_d = samp_q - 17'd1;
                  if (samp_q == 17'd1) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         dz_q    <= '0;
         t_q     <= '0;
         skip_q  <= '0;
         samp_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         dz_q    <= dz_d;
         t_q     <= t_d;
         skip_q  <= skip_d;
         samp_q  <= samp_d;
         done_q  <= done_d;
      end
   end

   assign out_valid_o = (state_q == ST_EMIT);
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign x_out_o     = x_q;
   assign y_out_o     = y_q;
   assign z_out_o     = z_q;

endmodule

// File: tb/tb_lorenz_fx_stream.sv
module tb_lorenz_fx_stream;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic signed [31:0] seed_x, seed_y, seed_z;

   logic start0, ready0, valid0, busy0, done0, sat0;
   logic signed [31:0] x0, y0, z0;
   logic start3, ready3, valid3, busy3, done3, sat3;
   logic signed [31:0] x3, y3, z3;
   logic start4, ready4, valid4, busy4, done4, sat4;
   logic signed [31:0] x4, y4, z4;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (wrap arithmetic, default coefficients, Q8.24)
   localparam longint M_SIGMA = 64'sd167772160;  // 10 << 24
   localparam longint M_RHO   = 64'sd469762048;  // 28 << 24
   localparam longint M_BETA  = 64'sd44739242;   // floor((8 << 24) / 3)
   longint mx, my, mz;

   lorenz_fx_stream u_dut (
      .clk(clk), .reset(reset), .start_i(start0),
      .seed_x_i(seed_x), .seed_y_i(seed_y), .seed_z_i(seed_z),
      .out_valid_o(valid0), .out_ready_i(ready0),
      .x_out_o(x0), .y_out_o(y0), .z_out_o(z0),
      .busy_o(busy0), .done_o(done0), .sat_flag_o(sat0)
   );

   lorenz_fx_stream #(.SKIP(3), .NSAMP(2)) u_skip (
      .clk(clk), .reset(reset), .start_i(start3),
      .seed_x_i(seed_x), .seed_y_i(seed_y), .seed_z_i(seed_z),
      .out_valid_o(valid3), .out_ready_i(ready3),
      .x_out_o(x3), .y_out_o(y3), .z_out_o(z3),
      .busy_o(busy3), .done_o(done3), .sat_flag_o(sat3)
   );

   lorenz_fx_stream #(.H_SHIFT(0)) u_sat (
      .clk(clk), .reset(reset), .start_i(start4),
      .seed_x_i(seed_x), .seed_y_i(seed_y), .seed_z_i(seed_z),
      .out_valid_o(valid4), .out_ready_i(ready4),
      .x_out_o(x4), .y_out_o(y4), .z_out_o(z4),
      .busy_o(busy4), .done_o(done4), .sat_flag_o(sat4)
   );

   function automatic longint wrap32(input longint v);
      return longint'(int'(v));
   endfunction

   function automatic void model_step(input int h);
      longint dx, dy, dz, t;
      dx = wrap32((M_SIGMA * (my - mx)) >>> 24);
      dy = wrap32(((mx * (M_RHO - mz)) >>> 24) - my);
      t  = wrap32((mx * my) >>> 24);
      dz = wrap32(t - ((M_BETA * mz) >>> 24));
      mx = wrap32(mx + (dx >>> h));
      my = wrap32(my + (dy >>> h));
      mz = wrap32(mz + (dz >>> h));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      start0 = 0; start3 = 0; start4 = 0;
      ready0 = 0; ready3 = 0; ready4 = 0;
      seed_x = 0; seed_y = 0; seed_z = 0;
      do_reset();
      n_checks++;
      if ({valid0, busy0, done0, sat0} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid/busy/done/sat=%b required 0000", {valid0, busy0, done0, sat0});
      end
      n_checks++;
      if (x0 !== 32'sd0 || y0 !== 32'sd0 || z0 !== 32'sd0) begin
         n_fail++;
         $display("FAIL reset_state: x=%h y=%h z=%h required 0", x0, y0, z0);
      end
      n_checks++;
      if ({valid3, busy3, done3, valid4, busy4, done4} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_other: ctrl=%b required 000000", {valid3, busy3, done3, valid4, busy4, done4});
      end
   endtask

   task automatic test_first_sample();
      int cyc;
      seed_x = 32'sh01000000; seed_y = 0; seed_z = 0;
      ready0 = 0;
      start0 = 1; tick(); start0 = 0;
      cyc = 1;
      while (!valid0 && cyc < 200) begin tick(); cyc++; end
      n_checks++;
      if (cyc !== 7) begin
         n_fail++;
         $display("FAIL first_latency: valid at cycle %0d required 7", cyc);
      end
      n_checks++;
      if (x0 !== 32'sh00F60000 || y0 !== 32'sh001C0000 || z0 !== 32'sh0) begin
         n_fail++;
         $display("FAIL first_sample: x=%h y=%h z=%h required 00f60000 001c0000 00000000", x0, y0, z0);
      end
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL first_busy: busy=%b required 1", busy0);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if (valid0 !== 1'b1 || x0 !== 32'sh00F60000 || y0 !== 32'sh001C0000 || z0 !== 32'sh0) begin
            n_fail++;
            $display("FAIL hold_%0d: valid=%b x=%h y=%h z=%h required 1 00f60000 001c0000 0", i, valid0, x0, y0, z0);
         end
      end
      ready0 = 1; tick(); ready0 = 0;
      n_checks++;
      if (valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_drop: valid=%b required 0", valid0);
      end
      mx = 64'sh01000000; my = 0; mz = 0;
      model_step(8);
      model_step(8);
      cyc = 1;
      while (!valid0 && cyc < 200) begin tick(); cyc++; end
      n_checks++;
      if (cyc !== 7 || longint'(x0) !== mx || longint'(y0) !== my || longint'(z0) !== mz) begin
         n_fail++;
         $display("FAIL second_sample: cyc=%0d x=%h y=%h z=%h required 7 %h %h %h", cyc, x0, y0, z0, mx[31:0], my[31:0], mz[31:0]);
      end
   endtask

   task automatic test_reset_midrun();
      int cyc;
      ready0 = 1; tick(); ready0 = 0;   // now in C1
      tick();                           // C2
      tick();                           // C3
      reset = 1; tick(); reset = 0;
      n_checks++;
      if ({valid0, busy0, done0, sat0} !== 4'b0000 || x0 !== 0 || y0 !== 0 || z0 !== 0) begin
         n_fail++;
         $display("FAIL midrun_reset: ctrl=%b x=%h y=%h z=%h required 0000 0 0 0", {valid0, busy0, done0, sat0}, x0, y0, z0);
      end
      seed_x = 32'sh01000000; seed_y = 0; seed_z = 0;
      start0 = 1; tick(); start0 = 0;
      cyc = 1;
      while (!valid0 && cyc < 200) begin tick(); cyc++; end
      n_checks++;
      if (cyc !== 7 || x0 !== 32'sh00F60000 || y0 !== 32'sh001C0000 || z0 !== 32'sh0) begin
         n_fail++;
         $display("FAIL restart_sample: cyc=%0d x=%h y=%h z=%h required 7 00f60000 001c0000 0", cyc, x0, y0, z0);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      ready0 = 0;
      do_reset();
      seed_x = 32'sh01000000; seed_y = 0; seed_z = 0;
      start0 = 1; tick(); start0 = 0;   // C1 of step 1
      seed_x = 32'sh05000000; seed_y = 32'sh03000000; seed_z = 32'sh02000000;
      mx = 64'sh01000000; my = 0; mz = 0;
      for (int k = 0; k < 3; k++) begin
         model_step(8);
         tick(); tick(); tick();         // C4
         start0 = 1; tick(); start0 = 0; // C5
         cyc = 5;
         while (!valid0 && cyc < 200) begin tick(); cyc++; end
         n_checks++;
         if (cyc !== 7 || longint'(x0) !== mx || longint'(y0) !== my || longint'(z0) !== mz) begin
            n_fail++;
            $display("FAIL ign_sample_%0d: cyc=%0d x=%h y=%h z=%h required 7 %h %h %h", k, cyc, x0, y0, z0, mx[31:0], my[31:0], mz[31:0]);
         end
         start0 = 1; tick(); start0 = 0;
         n_checks++;
         if (valid0 !== 1'b1 || busy0 !== 1'b1 || longint'(x0) !== mx) begin
            n_fail++;
            $display("FAIL ign_emit_%0d: valid=%b busy=%b x=%h required 1 1 %h", k, valid0, busy0, x0, mx[31:0]);
         end
         ready0 = 1; tick(); ready0 = 0;
      end
   endtask

   task automatic test_skip_nsamp();
      int cyc, first, acc, last_acc, dn, dcyc;
      first = -1; acc = 0; last_acc = -1; dn = 0; dcyc = -1;
      seed_x = 32'sh01000000; seed_y = 0; seed_z = 0;
      ready3 = 1;
      start3 = 1; tick(); start3 = 0;
      for (cyc = 1; cyc < 60; cyc++) begin
         if (valid3 && first < 0) first = cyc;
         if (valid3 && ready3) begin acc++; last_acc = cyc; end
         if (done3) begin dn++; dcyc = cyc; end
         tick();
      end
      n_checks++;
      if (first !== 25) begin
         n_fail++;
         $display("FAIL skip_latency: first valid cycle %0d required 25", first);
      end
      n_checks++;
      if (acc !== 2 || last_acc !== 32) begin
         n_fail++;
         $display("FAIL nsamp_accepts: accepts=%0d last=%0d required 2 32", acc, last_acc);
      end
      n_checks++;
      if (dn !== 1 || dcyc !== 33) begin
         n_fail++;
         $display("FAIL done_pulse: cycles=%0d at=%0d required 1 33", dn, dcyc);
      end
      n_checks++;
      if (busy3 !== 1'b0 || valid3 !== 1'b0) begin
         n_fail++;
         $display("FAIL run_end: busy=%b valid=%b required 0 0", busy3, valid3);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      logic signed [31:0] exp_y, exp_z;
      logic               exp_sat;
`ifdef LORENZ_SAT_EN
      exp_y = 32'sh7FFFFFFF; exp_z = 32'sh7FFFFFFF; exp_sat = 1'b1;
`else
      exp_y = 32'shE4000000; exp_z = 32'sh01000000; exp_sat = 1'b0;
`endif
      seed_x = 32'sh7F000000; seed_y = 32'sh7F000000; seed_z = 0;
      ready4 = 0;
      start4 = 1; tick(); start4 = 0;
      cyc = 1;
      while (!valid4 && cyc < 200) begin tick(); cyc++; end
      n_checks++;
      if (cyc !== 7 || x4 !== 32'sh7F000000) begin
         n_fail++;
         $display("FAIL sat_x: cyc=%0d x=%h required 7 7f000000", cyc, x4);
      end
      n_checks++;
      if (y4 !== exp_y || z4 !== exp_z) begin
         n_fail++;
         $display("FAIL sat_yz: y=%h z=%h required %h %h", y4, z4, exp_y, exp_z);
      end
      n_checks++;
      if (sat4 !== exp_sat) begin
         n_fail++;
         $display("FAIL sat_flag: got %b required %b", sat4, exp_sat);
      end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_first_sample();
      test_backpressure();
      test_reset_midrun();
      test_start_ignored();
      test_skip_nsamp();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
